// File: rtl/adc_cmd_sequencer.sv
// Host command sequencer in front of the ADC power/control FSM: validates each command,
// pulses one control strobe, waits for the target state and returns one response byte.
// Optional build macro: ADC_CMD_STATUS_QUERY_EN enables the 0x10 status query command.
module adc_cmd_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
  parameter int          ST_W           = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            CmdValid,
  input  logic [7:0]      CmdCode,
  output logic            CmdReady,
  input  logic [ST_W-1:0] AdcState,
  output logic            adcPwrOn,
  output logic            adcPwrOff,
  output logic            adcSleep,
  output logic            adcWake,
  output logic            adcRunCal,
  output logic            RespValid,
  output logic [7:0]      RespCode,
  input  logic            RespReady,
  output logic            Busy
);

  localparam logic [ST_W-1:0] ST_OFF      = ST_W'(0);
  localparam logic [ST_W-1:0] ST_CAL      = ST_W'(6);
  localparam logic [ST_W-1:0] ST_SAMPLING = ST_W'(8);
  localparam logic [ST_W-1:0] ST_LOW_PWR  = ST_W'(10);

  localparam logic [7:0] RESP_UNKNOWN  = 8'hE0;
  localparam logic [7:0] RESP_PRECOND  = 8'hE1;
  localparam logic [7:0] RESP_TIMEOUT  = 8'hE2;

  // Strobe mask bit order: {run_cal, wake, sleep, pwr_off, pwr_on}
  localparam logic [4:0] STB_PWR_ON  = 5'b00001;
  localparam logic [4:0] STB_PWR_OFF = 5'b00010;
  localparam logic [4:0] STB_SLEEP   = 5'b00100;
  localparam logic [4:0] STB_WAKE    = 5'b01000;
  localparam logic [4:0] STB_RUN_CAL = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PULSE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state, next_state;
  logic [7:0]        cmd_code;
  logic [ST_W-1:0]   start_state;
  logic [23:0]       timer;
  logic              seen_cal;
  logic [7:0]        resp_code;

  logic              resp_load;
  logic [7:0]        resp_next;

  logic              cmd_known;
  logic              pre_ok;
  logic [4:0]        stb_mask;
  logic [ST_W-1:0]   target;
  logic              is_cal;
  logic              timeout_hit;
  logic              at_target;
  logic              stb_en;

`ifdef ADC_CMD_STATUS_QUERY_EN
  logic              is_query;
  logic [3:0]        st_lo;

  assign st_lo = 4'(AdcState);
`endif

  // Command decode from the latched byte and the state captured at accept time.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    cmd_known = 1'b0;
    pre_ok    = 1'b0;
    stb_mask  = '0;
    target    = ST_OFF;
    is_cal    = 1'b0;
`ifdef ADC_CMD_STATUS_QUERY_EN
    is_query  = 1'b0;
`endif
    case (cmd_code)
      8'h01: begin
        cmd_known = 1'b1;
        pre_ok    = (start_state == ST_OFF);
        stb_mask  = STB_PWR_ON;
        target    = ST_SAMPLING;
      end
      8'h02: begin
        cmd_known = 1'b1;
        pre_ok    = (start_state == ST_SAMPLING) || (start_state == ST_LOW_PWR);
        stb_mask  = STB_PWR_OFF;
        target    = ST_OFF;
      end
      8'h03: begin
        cmd_known = 1'b1;
        pre_ok    = (start_state == ST_SAMPLING);
        stb_mask  = STB_SLEEP;
        target    = ST_LOW_PWR;
      end
      8'h04: begin
        cmd_known = 1'b1;
        pre_ok    = (start_state == ST_LOW_PWR);
        stb_mask  = STB_WAKE;
        target    = ST_SAMPLING;
      end
      8'h05: begin
        cmd_known = 1'b1;
        pre_ok    = (start_state == ST_SAMPLING);
        stb_mask  = STB_RUN_CAL;
        target    = ST_SAMPLING;
        is_cal    = 1'b1;
      end
`ifdef ADC_CMD_STATUS_QUERY_EN
      8'h10: begin
        cmd_known = 1'b1;
        is_query  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign timeout_hit = (timer >= (TIMEOUT_CYCLES - 24'd1));
  assign at_target   = is_cal ? (seen_cal && (AdcState == ST_SAMPLING))
                              : (AdcState == target);

  always_comb begin
    next_state = state;
    resp_load  = 1'b0;
    resp_next  = resp_code;
    case (state)
      S_IDLE: begin
        if (CmdValid) next_state = S_CHECK;
      end
      S_CHECK: begin
        resp_load  = 1'b1;
        next_state = S_RESP;
        if (!cmd_known) begin
          resp_next = RESP_UNKNOWN;
        end
`ifdef ADC_CMD_STATUS_QUERY_EN
        else if (is_query) begin
          resp_next = {4'h4, st_lo};
        end
`endif
        else if (!pre_ok) begin
          resp_next = RESP_PRECOND;
        end else begin
          resp_load  = 1'b0;
          next_state = S_PULSE;
        end
      end
      S_PULSE: begin
        if (timeout_hit) begin
          resp_load  = 1'b1;
          resp_next  = RESP_TIMEOUT;
          next_state = S_RESP;
        end else if (AdcState != start_state) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // A late success in the timeout cycle still reports success.
        if (at_target) begin
          resp_load  = 1'b1;
          resp_next  = {1'b1, cmd_code[6:0]};
          next_state = S_RESP;
        end else if (timeout_hit) begin
          resp_load  = 1'b1;
          resp_next  = RESP_TIMEOUT;
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (RespReady) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_IDLE;
      cmd_code    <= 8'h00;
      start_state <= '0;
      timer       <= '0;
      seen_cal    <= 1'b0;
      resp_code   <= 8'h00;
    end else begin
      state <= next_state;

      if (state == S_IDLE && CmdValid) begin
        cmd_code    <= CmdCode;
        start_state <= AdcState;
      end

      if (state == S_CHECK) begin
        timer    <= '0;
        seen_cal <= 1'b0;
      end else if (state == S_PULSE || state == S_WAIT) begin
        if (timer != '1) timer <= timer + 24'd1;
        if (AdcState == ST_CAL) seen_cal <= 1'b1;
      end

      if (resp_load) resp_code <= resp_next;
    end
  end

  // Strobes are decoded from state so the timeout can pull them low in the same cycle.
  assign stb_en    = (state == S_PULSE) && !timeout_hit;
  assign adcPwrOn  = stb_en & stb_mask[0];
  assign adcPwrOff = stb_en & stb_mask[1];
  assign adcSleep  = stb_en & stb_mask[2];
  assign adcWake   = stb_en & stb_mask[3];
  assign adcRunCal = stb_en & stb_mask[4];

  assign CmdReady  = (state == S_IDLE) && !Reset;
  assign RespValid = (state == S_RESP);
  assign RespCode  = resp_code;
  assign Busy      = (state == S_CHECK) || (state == S_PULSE) || (state == S_WAIT);

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// Directed self-checking bench for adc_cmd_sequencer with a shortened timeout (64 cycles).
module tb_adc_cmd_sequencer;

  localparam logic [23:0] TIMEOUT = 24'd64;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       CmdValid;
  logic [7:0] CmdCode;
  logic       CmdReady;
  logic [3:0] AdcState;
  logic       adcPwrOn, adcPwrOff, adcSleep, adcWake, adcRunCal;
  logic       RespValid;
  logic [7:0] RespCode;
  logic       RespReady;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  logic [4:0] strobes;
  int         stb_cnt [5];
  int         multi_cnt = 0;

  adc_cmd_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .ST_W          (4)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .CmdValid (CmdValid),
    .CmdCode  (CmdCode),
    .CmdReady (CmdReady),
    .AdcState (AdcState),
    .adcPwrOn (adcPwrOn),
    .adcPwrOff(adcPwrOff),
    .adcSleep (adcSleep),
    .adcWake  (adcWake),
    .adcRunCal(adcRunCal),
    .RespValid(RespValid),
    .RespCode (RespCode),
    .RespReady(RespReady),
    .Busy     (Busy)
  );

  always #5 Clock = ~Clock;

  assign strobes = {adcRunCal, adcWake, adcSleep, adcPwrOff, adcPwrOn};

  // Per-strobe high-cycle counters, sampled mid-cycle.
  initial for (int i = 0; i < 5; i++) stb_cnt[i] = 0;
  always @(negedge Clock) begin
    for (int i = 0; i < 5; i++) if (strobes[i]) stb_cnt[i]++;
    if ($countones(strobes) > 1) multi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] code);
    CmdCode  = code;
    CmdValid = 1'b1;
    tick();
    CmdValid = 1'b0;
  endtask

  function automatic int total_stb();
    return stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3] + stb_cnt[4];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int bad;
    logic [3:0] seq_on [6];
    logic [7:0] query_exp;

    Reset     = 1'b1;
    CmdValid  = 1'b0;
    CmdCode   = 8'h00;
    AdcState  = 4'd0;
    RespReady = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_cmd_ready", CmdReady, 1'b0);
    check("rst_strobes", strobes, 5'b0);
    check("rst_resp_valid", RespValid, 1'b0);
    check("rst_resp_code", RespCode, 8'h00);
    check("rst_busy", Busy, 1'b0);
    Reset = 1'b0;
    #1;
    check("idle_cmd_ready", CmdReady, 1'b1);

    // PWR_ON from off: strobe two cycles after accept, held until state leaves 0
    base = stb_cnt[0];
    send(8'h01);
    check("on_check_busy", Busy, 1'b1);
    check("on_check_no_stb", adcPwrOn, 1'b0);
    check("on_check_cmd_ready", CmdReady, 1'b0);
    tick();
    check("on_latency_stb", adcPwrOn, 1'b1);
    tick();
    check("on_held_stb", adcPwrOn, 1'b1);
    AdcState = 4'd1;
    tick();
    check("on_dropped_stb", adcPwrOn, 1'b0);
    check("on_wait_busy", Busy, 1'b1);
    seq_on = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8};
    for (int i = 0; i < 6; i++) begin
      AdcState = seq_on[i];
      tick();
    end
    check("on_resp_valid", RespValid, 1'b1);
    check("on_resp_code", RespCode, 8'h81);
    check("on_stb_cycles", stb_cnt[0] - base, 2);
    tick();
    check("on_resp_hold", RespValid, 1'b1);
    RespReady = 1'b1;
    tick();
    check("on_resp_done", RespValid, 1'b0);
    check("on_back_idle", CmdReady, 1'b1);

    // CAL with 12,5,6,8 and RespReady high on entry
    base = stb_cnt[4];
    send(8'h05);
    tick();
    check("cal_stb", adcRunCal, 1'b1);
    AdcState = 4'd12;
    tick();
    AdcState = 4'd5;
    tick();
    AdcState = 4'd6;
    tick();
    AdcState = 4'd8;
    tick();
    check("cal_resp_valid", RespValid, 1'b1);
    check("cal_resp_code", RespCode, 8'h85);
    check("cal_stb_cycles", stb_cnt[4] - base, 1);
    tick();
    check("cal_resp_one_cycle", RespValid, 1'b0);

    // CAL skipping state 6: must time out after 64 cycles
    send(8'h05);
    tick();
    n = 0;
    while (!RespValid && n < 200) begin
      if (n == 0) AdcState = 4'd12;
      else if (n == 1) AdcState = 4'd5;
      else if (n == 2) AdcState = 4'd8;
      tick();
      n++;
    end
    check("cal_skip_cycles", n, 64);
    check("cal_skip_code", RespCode, 8'hE2);
    tick();

    // PWR_OFF with frozen state: strobe high for TIMEOUT-1 cycles, low at timeout
    base = stb_cnt[1];
    AdcState = 4'd8;
    send(8'h02);
    tick();
    n = 0;
    while (!RespValid && n < 200) begin
      tick();
      n++;
      if (n == 63) begin
        check("off_timeout_stb_low", adcPwrOff, 1'b0);
        check("off_timeout_busy", Busy, 1'b1);
      end
    end
    check("off_timeout_cycles", n, 64);
    check("off_timeout_code", RespCode, 8'hE2);
    check("off_stb_cycles", stb_cnt[1] - base, 63);
    tick();

    // SLEEP from sampling
    base = stb_cnt[2];
    send(8'h03);
    tick();
    check("sleep_stb", adcSleep, 1'b1);
    AdcState = 4'd10;
    tick();
    tick();
    check("sleep_resp_code", RespCode, 8'h83);
    check("sleep_stb_cycles", stb_cnt[2] - base, 1);
    tick();

    // Error responses: no strobe may ever rise
    base = total_stb();
    AdcState = 4'd0;
    send(8'h03);
    tick();
    check("precond_resp_valid", RespValid, 1'b1);
    check("precond_code", RespCode, 8'hE1);
    tick();
    send(8'h7F);
    tick();
    check("unknown_code", RespCode, 8'hE0);
    tick();
    AdcState = 4'd10;
`ifdef ADC_CMD_STATUS_QUERY_EN
    query_exp = 8'h4A;
`else
    query_exp = 8'hE0;
`endif
    send(8'h10);
    tick();
    check("query_code", RespCode, query_exp);
    tick();
    check("err_no_strobe", total_stb() - base, 0);

    // Backpressure: response held, CmdValid ignored
    RespReady = 1'b0;
    send(8'h7F);
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      CmdValid = 1'b1;
      CmdCode  = 8'h01;
      tick();
      if (!RespValid || RespCode != 8'hE0 || CmdReady || Busy) bad++;
    end
    check("bp_stable_cycles", bad, 0);
    CmdValid  = 1'b0;
    RespReady = 1'b1;
    tick();
    check("bp_release", RespValid, 1'b0);
    tick();
    check("bp_cmd_ignored", Busy, 1'b0);
    check("bp_no_second_resp", RespValid, 1'b0);

    // Reset during PULSE aborts the command with no response
    AdcState = 4'd0;
    send(8'h01);
    tick();
    check("rst_pulse_stb", adcPwrOn, 1'b1);
    Reset = 1'b1;
    tick();
    check("rst_pulse_strobes", strobes, 5'b0);
    check("rst_pulse_resp", RespValid, 1'b0);
    check("rst_pulse_ready", CmdReady, 1'b0);
    Reset = 1'b0;
    bad = 0;
    for (int s = 1; s <= 8; s++) begin
      AdcState = 4'(s);
      tick();
      if (RespValid || Busy) bad++;
    end
    check("rst_no_resp", bad, 0);

    check("one_hot_strobes", multi_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
